// File: rtl/nn_seq_xor.sv
// nn_seq_xor: 2-2-1 binary neural network evaluated on one shared multiply-accumulate path.
// Define NN_SEQ_CFG_WR_EN to enable runtime weight writes; otherwise the weights are the fixed XOR set.
module nn_seq_xor #(
    parameter int unsigned W_W   = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           x0,
    input  logic           x1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           y,
    output logic           busy,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [W_W-1:0] cfg_wdata
);
    localparam int unsigned N_WT = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Default weight set: n0 = OR-like, n1 = NAND-like, n2 = AND of the two -> XOR.
    function automatic logic signed [W_W-1:0] w_default(input logic [3:0] a);
        case (a)
            4'd0, 4'd1, 4'd6, 4'd7: w_default = W_W'(20);
            4'd2:                   w_default = W_W'(-10);
            4'd3, 4'd4:             w_default = W_W'(-20);
            4'd5:                   w_default = W_W'(30);
            4'd8:                   w_default = W_W'(-30);
            default:                w_default = '0;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              step_q, step_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              h_q, h_d;
    logic [1:0]              xin_q, xin_d;
    logic                    y_q, y_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    logic signed [W_W-1:0]   wt_c [N_WT];
    logic                    accept_c;
    logic                    last_c;
    logic [3:0]              w_off_c;
    logic [3:0]              w_addr_c;
    logic signed [W_W-1:0]   w_sel_c;
    logic [1:0]              src_c;
    logic                    a_c;
    logic signed [ACC_W-1:0] term_c;

`ifdef NN_SEQ_CFG_WR_EN
    logic signed [W_W-1:0] w_q [N_WT];
    logic signed [W_W-1:0] w_d [N_WT];

    // Writes land only while idle; out-of-range addresses are dropped.
    always_comb begin
        w_d = w_q;
        if ((state_q == ST_IDLE) && cfg_we && (cfg_addr <= 4'd8)) begin
            w_d[cfg_addr] = cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_WT); i++) begin
                w_q[i] <= w_default(4'(i));
            end
        end else begin
            w_q <= w_d;
        end
    end

    assign wt_c = w_q;
`else
    logic cfg_unused_c;

    always_comb begin
        for (int i = 0; i < int'(N_WT); i++) begin
            wt_c[i] = w_default(4'(i));
        end
    end

    assign cfg_unused_c = cfg_we ^ (^cfg_addr) ^ (^cfg_wdata);
`endif

    assign accept_c = in_valid && in_ready_q;
    assign last_c   = (idx_q == 2'd2) && (step_q == 2'd3);

    // Operand select: step0 reads the bias, steps 1/2 read w0/w1 gated by the matching input bit.
    always_comb begin
        case (step_q)
            2'd1:    w_off_c = 4'd0;
            2'd2:    w_off_c = 4'd1;
            default: w_off_c = 4'd2;
        endcase
        w_addr_c = (4'(idx_q) * 4'd3) + w_off_c;
        w_sel_c  = wt_c[w_addr_c];
        src_c    = (idx_q == 2'd2) ? h_q : xin_q;
        a_c      = (step_q == 2'd1) ? src_c[0] : src_c[1];
        term_c   = a_c ? ACC_W'(w_sel_c) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)  state_d = ST_RUN;
            ST_RUN:  if (last_c)    state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        step_d      = step_q;
        acc_d       = acc_q;
        h_d         = h_q;
        xin_d       = xin_q;
        y_d         = y_q;
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    xin_d  = {x1, x0};
                    idx_d  = 2'd0;
                    step_d = 2'd0;
                end
            end
            ST_RUN: begin
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd0:       acc_d = ACC_W'(w_sel_c);
                    2'd1, 2'd2: acc_d = acc_q + term_c;
                    default: begin
                        // Step activation: fires when the sum is non-negative.
                        if (idx_q == 2'd2) begin
                            y_d   = ~acc_q[ACC_W-1];
                            idx_d = 2'd0;
                        end else begin
                            h_d[idx_q[0]] = ~acc_q[ACC_W-1];
                            idx_d         = idx_q + 2'd1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            h_q         <= '0;
            xin_q       <= '0;
            y_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            h_q         <= h_d;
            xin_q       <= xin_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign busy      = busy_q;

endmodule
